out_fifo_bank: RTL and testbench
================================

# out_fifo_bank

Four-lane output FIFO bank that buffers result words from the compute engine and presents them to the AXI4 read-response FSM. The producer pushes a word into any lane. The read FSM selects a lane with `out_fifo_pop_sel`, sees that lane's `out_fifo_empty` and head word, and pops it with `out_fifo_pop`. Each lane is an independent first-word-fall-through FIFO, so the read FSM can interleave AXI IDs across lanes.

## Interface
- `DATA_W`, 32: word width.
- `DEPTH`, 16: words per lane; power of two, at least 2. `AW = $clog2(DEPTH)`.
- `clk`  in  1  sole clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `in_push_valid`  in  1  producer offers a word.
- `in_push_lane`  in  2  target lane of the offered word.
- `in_push_data`  in  DATA_W  offered word.
- `in_push_ready`  out  1  the lane given by `in_push_lane` is not full.
- `out_fifo_pop_sel`  in  2  lane selected by the read FSM.
- `out_fifo_pop`  in  1  pop the head of the selected lane.
- `out_fifo_empty`  out  1  the selected lane is empty.
- `out_fifo_data`  out  DATA_W  head word of the selected lane.
- `lane_empty`  out  4  per-lane empty flags.
- `lane_full`  out  4  per-lane full flags.
- `lane_count`  out  4*(AW+1)  per-lane occupancy; lane n occupies bits [n*(AW+1) +: AW+1].
- `err_underflow`  out  4  per-lane sticky underflow flag; see Configuration.

## Operation
- Push is accepted when `in_push_valid && in_push_ready`. The word is written at that lane's write pointer and the pointer increments.
- Pop takes effect when `out_fifo_pop && !out_fifo_empty`. The selected lane's read pointer increments.
- A pop of an empty lane is ignored. Storage and pointers do not change.
- Pointers are AW+1 bits and wrap naturally.
  - Empty: pointers are equal.
  - Full: MSBs differ and the lower AW bits are equal.
  - Count: write pointer minus read pointer, modulo 2^(AW+1).
- Push and pop on the same lane in the same cycle: both take effect, and the count is unchanged.
  - This applies only if the lane is neither empty nor full.
  - Full lane: `in_push_ready` is 0, so only the pop occurs. There is no same-cycle bypass.
  - Empty lane: only the push occurs. The word is not visible at the head until the next cycle.
- Push and pop on different lanes in the same cycle: both are fully independent.
- `out_fifo_empty`, `out_fifo_data` and `in_push_ready` are combinational muxes of registered per-lane state by the select inputs.
- `out_fifo_data` is 0 whenever the selected lane is empty.
- Reset values: all pointers and counts 0; `lane_empty` 4'hF; `lane_full` 0; `in_push_ready` 1; `out_fifo_empty` 1; `out_fifo_data` 0; `err_underflow` 0.
- Storage RAM is not reset.
- Reset asserted mid-operation discards all lane contents immediately, asynchronously.

## Timing
- Push to visibility: a word pushed at edge N is at the head, with `out_fifo_empty` = 0, from just after edge N. That means the cycle following the push.
- Pop to next head: a pop at edge N shows the next word, or empty, from just after edge N.
- Full/empty flags and counts update on the same edge as the push or pop that changes them.
- Select changes: a change of `out_fifo_pop_sel` or `in_push_lane` is reflected in the muxed outputs within the same cycle.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- `OUT_FIFO_BANK_ERR_EN` defined:
  - A pop attempted while the selected lane is empty sets `err_underflow[sel]` on that edge.
  - The flag holds until reset.
- Not defined: `err_underflow` is tied to 0 and no error logic is synthesized.

## Structure
- Package `out_fifo_pkg`:
  - `NUM_LANES` = 4 and `LANE_W` = 2.
  - `lane_t` typedef (logic [1:0]).
- One sub-module, `lane_fifo`: a single-lane FWFT FIFO with push, pop, empty, full, count and head outputs, parameterized by `DATA_W` and `DEPTH`.
  - Instantiated `NUM_LANES` times in a generate loop.
  - The top level holds only the lane decode, the output muxes and the error flags.

## Test plan
- Reset then idle: all `lane_empty` = 4'hF, `in_push_ready` = 1, `out_fifo_data` = 0, all counts 0.
- Push 0xA0..0xA3 into lane 2, select lane 2, pop 4 times: the data reads A0, A1, A2, A3 in order, then `out_fifo_empty` = 1 and `lane_count[2]` = 0.
- Fill lane 1 with 16 words: `lane_full[1]` = 1 and `in_push_ready` = 0 for lane 1. A 17th push is refused. A simultaneous push and pop on full lane 1 leaves the count at 15.
- Wrap-around: 40 pushes and 40 pops on lane 0 with random gaps. The data is in order, and the pointers wrap without a false full or empty.
- Interleave: push to lanes 0 and 3 while popping lane 3 every cycle. Lane 0 is unaffected and lane 3 data is in order.
- With `OUT_FIFO_BANK_ERR_EN`: a pop on empty lane 3 sets `err_underflow` = 4'b1000, which stays set after later valid traffic. Reset asserted mid-fill clears all lanes and the flag.

Source files
------------

// File: rtl/out_fifo_pkg.sv
// Shared lane constants and types for the four-lane output FIFO bank.
package out_fifo_pkg;
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned LANE_W    = 2;

   typedef logic [LANE_W-1:0] lane_t;
endpackage

// File: rtl/out_fifo_bank_if.sv
// Producer push / read-FSM pop handshake between the bank and its neighbours.
interface out_fifo_bank_if
   import out_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) ();
   logic              in_push_valid;
   lane_t             in_push_lane;
   logic [DATA_W-1:0] in_push_data;
   logic              in_push_ready;
   lane_t             out_fifo_pop_sel;
   logic              out_fifo_pop;
   logic              out_fifo_empty;
   logic [DATA_W-1:0] out_fifo_data;

   modport master (
      output in_push_valid, in_push_lane, in_push_data, out_fifo_pop_sel, out_fifo_pop,
      input  in_push_ready, out_fifo_empty, out_fifo_data
   );

   modport slave (
      input  in_push_valid, in_push_lane, in_push_data, out_fifo_pop_sel, out_fifo_pop,
      output in_push_ready, out_fifo_empty, out_fifo_data
   );
endinterface

// File: rtl/lane_fifo.sv
// Single-lane first-word-fall-through FIFO; head reads 0 while the lane is empty.
module lane_fifo #(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned DEPTH  = 16,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              empty,
   output logic              full,
   output logic [AW:0]       count,
   output logic [DATA_W-1:0] head
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wptr;
   logic [AW:0]       rptr;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage is deliberately not reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_data;
   end

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count = wptr - rptr;
   assign head  = empty ? '0 : mem[rptr[AW-1:0]];
endmodule

// File: rtl/out_fifo_bank.sv
// Four independent FWFT lanes with select-muxed head/empty/ready toward the read FSM.
// Optional sticky underflow flags are built when OUT_FIFO_BANK_ERR_EN is defined.
module out_fifo_bank
   import out_fifo_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned DEPTH  = 16,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          reset,
   out_fifo_bank_if.slave                bus,
   output logic [NUM_LANES-1:0]          lane_empty,
   output logic [NUM_LANES-1:0]          lane_full,
   output logic [NUM_LANES*(AW+1)-1:0]   lane_count,
   output logic [NUM_LANES-1:0]          err_underflow
);
   logic [NUM_LANES-1:0] push_lane;
   logic [NUM_LANES-1:0] pop_lane;
   logic [DATA_W-1:0]    head [NUM_LANES];

   // Steer the push and pop strobes to their lanes.
   always_comb begin
      push_lane = '0;
      pop_lane  = '0;
      push_lane[bus.in_push_lane]     = bus.in_push_valid;
      pop_lane[bus.out_fifo_pop_sel]  = bus.out_fifo_pop;
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .push      (push_lane[g]),
         .push_data (bus.in_push_data),
         .pop       (pop_lane[g]),
         .empty     (lane_empty[g]),
         .full      (lane_full[g]),
         .count     (lane_count[g*(AW+1) +: (AW+1)]),
         .head      (head[g])
      );
   end

   assign bus.in_push_ready  = !lane_full[bus.in_push_lane];
   assign bus.out_fifo_empty = lane_empty[bus.out_fifo_pop_sel];
   assign bus.out_fifo_data  = head[bus.out_fifo_pop_sel];

`ifdef OUT_FIFO_BANK_ERR_EN
   // A pop against an empty lane latches that lane's flag until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_underflow <= '0;
      end else if (bus.out_fifo_pop && bus.out_fifo_empty) begin
         err_underflow[bus.out_fifo_pop_sel] <= 1'b1;
      end
   end
`else
   assign err_underflow = '0;
`endif
endmodule

// File: tb/tb_out_fifo_bank.sv
// Randomized bench for out_fifo_bank against a per-lane queue model.
module tb_out_fifo_bank;
   import out_fifo_pkg::*;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int CW     = 5;

   logic clk = 1'b0;
   logic reset;
   logic [3:0]      lane_empty;
   logic [3:0]      lane_full;
   logic [3:0]      err_underflow;
   logic [4*CW-1:0] lane_count;

   out_fifo_bank_if #(.DATA_W(DATA_W)) bus ();

   out_fifo_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .lane_empty    (lane_empty),
      .lane_full     (lane_full),
      .lane_count    (lane_count),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] q [4][$];
   logic [3:0] err_m = 4'h0;

   task automatic idle();
      bus.in_push_valid    = 1'b0;
      bus.in_push_lane     = 2'd0;
      bus.in_push_data     = '0;
      bus.out_fifo_pop_sel = 2'd0;
      bus.out_fifo_pop     = 1'b0;
   endtask

   // Advance one rising edge and apply the same transfer to the model.
   task automatic step();
      bit    ph, pp;
      lane_t pl, ps;
      @(posedge clk);
      pl = bus.in_push_lane;
      ps = bus.out_fifo_pop_sel;
      ph = bus.in_push_valid && (q[pl].size() < DEPTH);
      pp = bus.out_fifo_pop && (q[ps].size() != 0);
      if (bus.out_fifo_pop && q[ps].size() == 0) err_m[ps] = 1'b1;
      if (pp) void'(q[ps].pop_front());
      if (ph) q[pl].push_back(bus.in_push_data);
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      #23;
      reset = 1'b1;
      #10;
      n_checks++; if (lane_empty !== 4'hF) begin n_fail++; $display("FAIL reset_lane_empty got %h exp F", lane_empty); end
      n_checks++; if (lane_full !== 4'h0) begin n_fail++; $display("FAIL reset_lane_full got %h exp 0", lane_full); end
      n_checks++; if (lane_count !== '0) begin n_fail++; $display("FAIL reset_count got %h exp 0", lane_count); end
      n_checks++; if (bus.in_push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.in_push_ready); end
      n_checks++; if (bus.out_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", bus.out_fifo_empty); end
      n_checks++; if (bus.out_fifo_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", bus.out_fifo_data); end
      n_checks++; if (err_underflow !== 4'h0) begin n_fail++; $display("FAIL reset_err got %h exp 0", err_underflow); end
   endtask

   task automatic test_order();
      idle();
      bus.out_fifo_pop_sel = 2'd2;
      for (int i = 0; i < 4; i++) begin
         bus.in_push_valid = 1'b1;
         bus.in_push_lane  = 2'd2;
         bus.in_push_data  = 32'hA0 + 32'(i);
         step();
      end
      bus.in_push_valid = 1'b0;
      n_checks++; if (lane_count[2*CW +: CW] !== 5'd4) begin n_fail++; $display("FAIL order_count4 got %0d exp 4", lane_count[2*CW +: CW]); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (bus.out_fifo_empty !== 1'b0) begin n_fail++; $display("FAIL order_nonempty[%0d] got %b exp 0", i, bus.out_fifo_empty); end
         n_checks++; if (bus.out_fifo_data !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL order_data[%0d] got %h exp %h", i, bus.out_fifo_data, 32'hA0 + 32'(i)); end
         bus.out_fifo_pop = 1'b1;
         step();
      end
      bus.out_fifo_pop = 1'b0;
      n_checks++; if (bus.out_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL order_empty got %b exp 1", bus.out_fifo_empty); end
      n_checks++; if (lane_count[2*CW +: CW] !== 5'd0) begin n_fail++; $display("FAIL order_count0 got %0d exp 0", lane_count[2*CW +: CW]); end
      n_checks++; if (bus.out_fifo_data !== '0) begin n_fail++; $display("FAIL order_data_empty got %h exp 0", bus.out_fifo_data); end
   endtask

   task automatic test_full();
      idle();
      bus.in_push_lane     = 2'd1;
      bus.out_fifo_pop_sel = 2'd1;
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++; if (bus.in_push_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_fill[%0d] got %b exp 1", i, bus.in_push_ready); end
         bus.in_push_valid = 1'b1;
         bus.in_push_data  = $urandom;
         step();
      end
      n_checks++; if (lane_full[1] !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b exp 1", lane_full[1]); end
      n_checks++; if (bus.in_push_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", bus.in_push_ready); end
      bus.in_push_data = 32'hDEAD_BEEF;
      step();
      n_checks++; if (lane_count[CW +: CW] !== 5'd16) begin n_fail++; $display("FAIL full_17th_count got %0d exp 16", lane_count[CW +: CW]); end
      bus.out_fifo_pop = 1'b1;
      step();
      bus.in_push_valid = 1'b0;
      bus.out_fifo_pop  = 1'b0;
      n_checks++; if (lane_count[CW +: CW] !== 5'd15) begin n_fail++; $display("FAIL full_pushpop_count got %0d exp 15", lane_count[CW +: CW]); end
      n_checks++; if (lane_full[1] !== 1'b0) begin n_fail++; $display("FAIL full_after_pop got %b exp 0", lane_full[1]); end
      // Drain and confirm the refused word never entered the lane.
      for (int i = 0; i < 20 && q[1].size() != 0; i++) begin
         n_checks++; if (bus.out_fifo_data !== q[1][0]) begin n_fail++; $display("FAIL full_drain[%0d] got %h exp %h", i, bus.out_fifo_data, q[1][0]); end
         bus.out_fifo_pop = 1'b1;
         step();
      end
      bus.out_fifo_pop = 1'b0;
      n_checks++; if (lane_empty[1] !== 1'b1) begin n_fail++; $display("FAIL full_drained got %b exp 1", lane_empty[1]); end
   endtask

   task automatic test_wrap();
      int pushed = 0;
      int popped = 0;
      int cyc    = 0;
      idle();
      while ((pushed < 40 || popped < 40) && cyc < 2000) begin
         bus.in_push_lane     = 2'd0;
         bus.out_fifo_pop_sel = 2'd0;
         bus.in_push_valid    = (pushed < 40) && ($urandom_range(2) != 0);
         bus.in_push_data     = 32'hB000_0000 + 32'(pushed);
         bus.out_fifo_pop     = (q[0].size() != 0) && ($urandom_range(1) != 0);
         #1;
         n_checks++; if (lane_empty[0] !== (q[0].size() == 0)) begin n_fail++; $display("FAIL wrap_empty c%0d got %b exp %b", cyc, lane_empty[0], q[0].size() == 0); end
         n_checks++; if (lane_full[0] !== (q[0].size() == DEPTH)) begin n_fail++; $display("FAIL wrap_full c%0d got %b exp %b", cyc, lane_full[0], q[0].size() == DEPTH); end
         n_checks++; if (lane_count[0 +: CW] !== CW'(q[0].size())) begin n_fail++; $display("FAIL wrap_count c%0d got %0d exp %0d", cyc, lane_count[0 +: CW], q[0].size()); end
         if (bus.out_fifo_pop) begin
            n_checks++; if (bus.out_fifo_data !== 32'hB000_0000 + 32'(popped)) begin n_fail++; $display("FAIL wrap_data c%0d got %h exp %h", cyc, bus.out_fifo_data, 32'hB000_0000 + 32'(popped)); end
            popped++;
         end
         if (bus.in_push_valid && q[0].size() < DEPTH) pushed++;
         step();
         cyc++;
      end
      idle();
      n_checks++; if (cyc >= 2000) begin n_fail++; $display("FAIL wrap_timeout got %0d pops exp 40", popped); end
      n_checks++; if (lane_empty[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_final_empty got %b exp 1", lane_empty[0]); end
   endtask

`ifdef OUT_FIFO_BANK_ERR_EN
   task automatic test_err();
      idle();
      n_checks++; if (err_underflow !== 4'h0) begin n_fail++; $display("FAIL err_pre got %h exp 0", err_underflow); end
      bus.out_fifo_pop_sel = 2'd3;
      bus.out_fifo_pop     = 1'b1;
      step();
      bus.out_fifo_pop = 1'b0;
      n_checks++; if (err_underflow !== 4'b1000) begin n_fail++; $display("FAIL err_set got %h exp 8", err_underflow); end
      bus.in_push_valid = 1'b1;
      bus.in_push_lane  = 2'd3;
      bus.in_push_data  = $urandom;
      step();
      bus.in_push_valid = 1'b0;
      bus.out_fifo_pop  = 1'b1;
      step();
      bus.out_fifo_pop = 1'b0;
      n_checks++; if (err_underflow !== 4'b1000) begin n_fail++; $display("FAIL err_sticky got %h exp 8", err_underflow); end
      n_checks++; if (err_underflow !== err_m) begin n_fail++; $display("FAIL err_model got %h exp %h", err_underflow, err_m); end
   endtask
`endif

   task automatic test_interleave();
      logic [DATA_W-1:0] first0 = '0;
      int n0 = 0;
      idle();
      bus.out_fifo_pop_sel = 2'd3;
      bus.out_fifo_pop     = 1'b1;
      for (int i = 0; i < 30; i++) begin
         bus.in_push_valid = 1'b1;
         bus.in_push_lane  = (i % 2 == 0) ? 2'd0 : 2'd3;
         bus.in_push_data  = $urandom;
         if (i == 0) first0 = bus.in_push_data;
         if (i % 2 == 0) n0++;
         #1;
         n_checks++; if (bus.out_fifo_empty !== (q[3].size() == 0)) begin n_fail++; $display("FAIL ilv_empty3[%0d] got %b exp %b", i, bus.out_fifo_empty, q[3].size() == 0); end
         if (q[3].size() != 0) begin
            n_checks++; if (bus.out_fifo_data !== q[3][0]) begin n_fail++; $display("FAIL ilv_data3[%0d] got %h exp %h", i, bus.out_fifo_data, q[3][0]); end
         end
         step();
         n_checks++; if (lane_count[0 +: CW] !== CW'(n0)) begin n_fail++; $display("FAIL ilv_count0[%0d] got %0d exp %0d", i, lane_count[0 +: CW], n0); end
      end
      bus.in_push_valid = 1'b0;
      bus.out_fifo_pop  = 1'b0;
      bus.out_fifo_pop_sel = 2'd0;
      #1;
      n_checks++; if (bus.out_fifo_data !== first0) begin n_fail++; $display("FAIL ilv_sel_switch got %h exp %h", bus.out_fifo_data, first0); end
      bus.in_push_lane = 2'd0;
      #1;
      n_checks++; if (bus.in_push_ready !== 1'b1) begin n_fail++; $display("FAIL ilv_ready0 got %b exp 1", bus.in_push_ready); end
   endtask

   task automatic test_reset_mid();
      idle();
      for (int i = 0; i < 5; i++) begin
         bus.in_push_valid = 1'b1;
         bus.in_push_lane  = lane_t'(i % 2 + 1);
         bus.in_push_data  = $urandom;
         step();
      end
      idle();
      reset = 1'b0;
      #2;
      for (int l = 0; l < 4; l++) begin
         q[l].delete();
      end
      err_m = 4'h0;
      n_checks++; if (lane_empty !== 4'hF) begin n_fail++; $display("FAIL midrst_empty got %h exp F", lane_empty); end
      n_checks++; if (lane_count !== '0) begin n_fail++; $display("FAIL midrst_count got %h exp 0", lane_count); end
      n_checks++; if (bus.out_fifo_data !== '0) begin n_fail++; $display("FAIL midrst_data got %h exp 0", bus.out_fifo_data); end
      n_checks++; if (err_underflow !== 4'h0) begin n_fail++; $display("FAIL midrst_err got %h exp 0", err_underflow); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.in_push_valid = 1'b1;
      bus.in_push_lane  = 2'd1;
      bus.in_push_data  = 32'h1234_5678;
      bus.out_fifo_pop_sel = 2'd1;
      step();
      idle();
      bus.out_fifo_pop_sel = 2'd1;
      #1;
      n_checks++; if (bus.out_fifo_data !== 32'h1234_5678) begin n_fail++; $display("FAIL postrst_data got %h exp 12345678", bus.out_fifo_data); end
      n_checks++; if (lane_count[CW +: CW] !== 5'd1) begin n_fail++; $display("FAIL postrst_count got %0d exp 1", lane_count[CW +: CW]); end
   endtask

   initial begin
      test_reset();
      test_order();
      test_full();
      test_wrap();
`ifdef OUT_FIFO_BANK_ERR_EN
      test_err();
`endif
      test_interleave();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
